sha_digest_acc: RTL and testbench

SHA_DIGEST_ACC -- requirements
Module: sha_digest_acc

---
 rtl/sha_digest_pkg.sv | 42 ++++
 rtl/sha_lane_add.sv | 19 +
 rtl/sha_digest_acc.sv | 175 +++++++++++++++++
 tb/tb_sha_digest_acc.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_digest_pkg.sv
// sha_digest_pkg -- shared definitions for the SHA digest accumulator.
//   - Initial hash values for SHA-224, SHA-256, SHA-384 and SHA-512,
//     packed with H0 in the MSBs.
//   - Accumulator state enum.
//   - Legal word-width check, used at elaboration time by the top.
package sha_digest_pkg;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] SHA224_IV = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [511:0] SHA512_IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam logic [511:0] SHA384_IV = {
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507,
    64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511,
    64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
  };

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OUT  = 1'b1
  } acc_state_e;

  // Only the SHA-256 family (32-bit) and SHA-512 family (64-bit) word sizes exist.
  function automatic bit word_w_legal(input int unsigned w);
    return (w == 32'd32) || (w == 32'd64);
  endfunction

endpackage

// File: rtl/sha_lane_add.sv
// sha_lane_add -- eight independent modulo-2^WORD_W adders, purely combinational.
// Ports:
//   base   in  8*WORD_W  chaining value H0..H7 (H0 in the MSBs)
//   addend in  8*WORD_W  working variables a..h (a in the MSBs)
//   sum    out 8*WORD_W  lane-wise base+addend, carries dropped per lane
module sha_lane_add #(
  parameter int WORD_W = 32
) (
  input  logic [8*WORD_W-1:0] base,
  input  logic [8*WORD_W-1:0] addend,
  output logic [8*WORD_W-1:0] sum
);

  for (genvar i = 0; i < 8; i++) begin : g_lane
    // Each lane is its own WORD_W-bit add, so no carry crosses lanes.
    assign sum[i*WORD_W +: WORD_W] = base[i*WORD_W +: WORD_W] + addend[i*WORD_W +: WORD_W];
  end

endmodule

// File: rtl/sha_digest_acc.sv
// sha_digest_acc -- folds compressed working variables into the running SHA
// chaining value and presents the final digest with a valid/ready handshake.
// Optional feature macro: SHA_DIGEST_TRUNC_EN (adds the trunc port, selecting
// the SHA-224/SHA-384 IV and zeroing the truncated digest words).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  block handshake (in_ready is 1 only in IDLE)
//   in_first/last   message framing flags, qualified by in_valid
//   in_words        working variables a..h, a in the MSBs
//   digest_valid/ready  digest handshake
//   digest          H0..H7 (H0 in the MSBs), zero unless digest_valid
//   blk_cnt         saturating count of blocks in the current message
//   trunc           (macro only) truncated-variant select, sampled with in_first
module sha_digest_acc
  import sha_digest_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
`ifdef SHA_DIGEST_TRUNC_EN
  input  logic                trunc,
`endif
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_first,
  input  logic                in_last,
  input  logic [8*WORD_W-1:0] in_words,
  output logic                digest_valid,
  input  logic                digest_ready,
  output logic [8*WORD_W-1:0] digest,
  output logic [CNT_W-1:0]    blk_cnt
);

  localparam int DW = 8 * WORD_W;

  if (!word_w_legal(WORD_W)) begin : g_bad_word_w
    $error("sha_digest_acc: WORD_W must be 32 or 64");
  end

  logic [DW-1:0] iv_full;
  logic [DW-1:0] iv_trunc;

  if (WORD_W == 64) begin : g_iv64
    assign iv_full  = SHA512_IV[DW-1:0];
    assign iv_trunc = SHA384_IV[DW-1:0];
  end else begin : g_iv32
    assign iv_full  = SHA256_IV[DW-1:0];
    assign iv_trunc = SHA224_IV[DW-1:0];
  end

  acc_state_e       state;
  logic [DW-1:0]    h;
  logic             open;
  logic             trunc_mode;
  logic             trunc_sel;
  logic             accept;
  logic [DW-1:0]    base;
  logic [DW-1:0]    sum;
  logic [DW-1:0]    masked;
  logic [CNT_W-1:0] cnt_next;

  // trunc only matters when a block starts a message; otherwise the
  // variant chosen at the start of the open message is kept.
`ifdef SHA_DIGEST_TRUNC_EN
  assign trunc_sel = in_first ? trunc : trunc_mode;
`else
  assign trunc_sel = 1'b0;
`endif

  assign accept = (state == ST_IDLE) && in_valid && in_ready;

  // Chain base: a fresh IV when starting (explicitly or with no open message).
  always_comb begin
    base = h;
    if (in_first || !open) begin
      if (trunc_sel) begin
        base = iv_trunc;
      end else begin
        base = iv_full;
      end
    end else begin
      base = h;
    end
  end

  sha_lane_add #(.WORD_W(WORD_W)) u_lane_add (
    .base   (base),
    .addend (in_words),
    .sum    (sum)
  );

  // Block count for the accepted block: restarts at 1, saturates at all-ones.
  always_comb begin
    cnt_next = blk_cnt;
    if (in_first || !open) begin
      cnt_next = CNT_W'(1);
    end else if (blk_cnt == {CNT_W{1'b1}}) begin
      cnt_next = blk_cnt;
    end else begin
      cnt_next = blk_cnt + CNT_W'(1);
    end
  end

  // Truncated variants drop the low word(s): H7 for SHA-224, H6..H7 for SHA-384.
  always_comb begin
    masked = sum;
    if (trunc_sel) begin
      if (WORD_W == 64) begin
        masked[2*WORD_W-1:0] = {(2*WORD_W){1'b0}};
      end else begin
        masked[WORD_W-1:0] = {WORD_W{1'b0}};
      end
    end else begin
      masked = sum;
    end
  end

  // Accumulator FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      h            <= iv_full;
      open         <= 1'b0;
      trunc_mode   <= 1'b0;
      blk_cnt      <= {CNT_W{1'b0}};
      digest_valid <= 1'b0;
      digest       <= {DW{1'b0}};
      in_ready     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            h          <= sum;
            open       <= 1'b1;
            trunc_mode <= trunc_sel;
            blk_cnt    <= cnt_next;
            if (in_last) begin
              state        <= ST_OUT;
              in_ready     <= 1'b0;
              digest_valid <= 1'b1;
              digest       <= masked;
            end
          end
        end
        ST_OUT: begin
          // Digest and count hold until the consumer takes the digest.
          if (digest_ready) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b1;
            digest_valid <= 1'b0;
            digest       <= {DW{1'b0}};
            h            <= iv_full;
            open         <= 1'b0;
            trunc_mode   <= 1'b0;
            blk_cnt      <= {CNT_W{1'b0}};
          end
        end
        default: begin
          state        <= ST_IDLE;
          in_ready     <= 1'b0;
          digest_valid <= 1'b0;
          digest       <= {DW{1'b0}};
          h            <= iv_full;
          open         <= 1'b0;
          trunc_mode   <= 1'b0;
          blk_cnt      <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_digest_acc.sv
// Self-checking bench for sha_digest_acc: a 32-bit instance driven with
// directed and random messages against a word-array reference model, and a
// 64-bit instance with a 2-bit counter for the wide IV and count saturation.
module tb_sha_digest_acc;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_first, in_last, in_ready;
  logic [255:0] in_words;
  logic         digest_valid, digest_ready;
  logic [255:0] digest;
  logic [15:0]  blk_cnt;
  logic         trunc_val = 1'b0;

  logic         in_valid64, in_first64, in_last64, in_ready64;
  logic [511:0] in_words64;
  logic         digest_valid64, digest_ready64;
  logic [511:0] digest64;
  logic [1:0]   blk_cnt64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sha_digest_acc dut (
`ifdef SHA_DIGEST_TRUNC_EN
    .trunc        (trunc_val),
`endif
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_first     (in_first),
    .in_last      (in_last),
    .in_words     (in_words),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .digest       (digest),
    .blk_cnt      (blk_cnt)
  );

  sha_digest_acc #(.WORD_W(64), .CNT_W(2)) dut64 (
`ifdef SHA_DIGEST_TRUNC_EN
    .trunc        (1'b0),
`endif
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid64),
    .in_ready     (in_ready64),
    .in_first     (in_first64),
    .in_last      (in_last64),
    .in_words     (in_words64),
    .digest_valid (digest_valid64),
    .digest_ready (digest_ready64),
    .digest       (digest64),
    .blk_cnt      (blk_cnt64)
  );

  // ---------------- reference model (word arrays, plain arithmetic) -------
  logic [31:0] iv256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] iv224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                             32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  logic [63:0] iv512 [8] = '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
                             64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                             64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                             64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

  logic [31:0] mh [8];
  logic [31:0] blk_w [8];
  bit          mopen;
  bit          mtrunc;
  int unsigned mcnt;

  function automatic void model_close();
    mopen  = 1'b0;
    mtrunc = 1'b0;
    mcnt   = 0;
  endfunction

  function automatic void model_accept(input bit first, input bit tr);
    if (first || !mopen) begin
      mtrunc = first ? tr : 1'b0;
      for (int i = 0; i < 8; i++) mh[i] = mtrunc ? iv224[i] : iv256[i];
      mcnt = 0;
    end
    for (int i = 0; i < 8; i++) mh[i] = mh[i] + blk_w[i];
    mcnt  = (mcnt >= 65535) ? 65535 : mcnt + 1;
    mopen = 1'b1;
  endfunction

  function automatic logic [255:0] model_digest();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[255-32*i -: 32] = (mtrunc && i == 7) ? 32'h0 : mh[i];
    return d;
  endfunction

  function automatic logic [255:0] pack_blk();
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[255-32*i -: 32] = blk_w[i];
    return p;
  endfunction

  // ---------------- drivers (no comparisons) --------------------------------
  task automatic offer32(input bit first, input bit last, output bit ok);
    @(negedge clk);
    in_valid = 1'b1; in_first = first; in_last = last; in_words = pack_blk();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    if (ok) model_accept(first, trunc_val);
  endtask

  task automatic offer64(input bit first, input bit last, output bit ok);
    @(negedge clk);
    in_valid64 = 1'b1; in_first64 = first; in_last64 = last; in_words64 = 512'h0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready64 === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    in_valid64 = 1'b0; in_first64 = 1'b0; in_last64 = 1'b0;
  endtask

  task automatic consume32();
    digest_ready = 1'b1;
    @(posedge clk);
    #1;
    digest_ready = 1'b0;
    model_close();
  endtask

  // ---------------- tests ----------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_words = 256'h0; digest_ready = 1'b0;
    in_valid64 = 1'b0; in_first64 = 1'b0; in_last64 = 1'b0; in_words64 = 512'h0; digest_ready64 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (digest_valid !== 1'b0) begin bad++; $display("FAIL rst_digest_valid got=%b exp=0", digest_valid); end
    total++; if (digest !== 256'h0) begin bad++; $display("FAIL rst_digest got=%h exp=0", digest); end
    total++; if (blk_cnt !== 16'h0) begin bad++; $display("FAIL rst_blk_cnt got=%0d exp=0", blk_cnt); end
    rst = 1'b0;
    model_close();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
    total++; if (in_ready64 !== 1'b1) begin bad++; $display("FAIL rst_release_ready64 got=%b exp=1", in_ready64); end
  endtask

  task automatic test_zero_block();
    bit ok;
    for (int i = 0; i < 8; i++) blk_w[i] = 32'h0;
    offer32(1'b1, 1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_accept timeout"); end
    @(negedge clk);
    total++; if (digest_valid !== 1'b1) begin bad++; $display("FAIL zero_valid_latency got=%b exp=1", digest_valid); end
    total++; if (digest !== 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19)
      begin bad++; $display("FAIL zero_digest got=%h", digest); end
    total++; if (blk_cnt !== 16'd1) begin bad++; $display("FAIL zero_blk_cnt got=%0d exp=1", blk_cnt); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL zero_out_ready got=%b exp=0", in_ready); end
    consume32();
    @(negedge clk);
    total++; if (digest !== 256'h0 || digest_valid !== 1'b0)
      begin bad++; $display("FAIL zero_after_consume got=%h v=%b exp=0", digest, digest_valid); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] lane_in  [2] = '{32'h95f61999, 32'h95f61998};
    logic [31:0] lane_exp [2] = '{32'h00000000, 32'hffffffff};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) blk_w[i] = 32'h0;
      blk_w[0] = lane_in[k];
      offer32(1'b1, 1'b1, ok);
      total++; if (!ok) begin bad++; $display("FAIL wrap_accept timeout k=%0d", k); end
      @(negedge clk);
      total++; if (digest[255:224] !== lane_exp[k])
        begin bad++; $display("FAIL wrap_h0 got=%h exp=%h", digest[255:224], lane_exp[k]); end
      total++; if (digest !== model_digest())
        begin bad++; $display("FAIL wrap_digest got=%h exp=%h", digest, model_digest()); end
      consume32();
    end
  endtask

  task automatic test_chaining();
    bit ok1, ok2;
    for (int i = 0; i < 8; i++) blk_w[i] = 32'h1;
    offer32(1'b1, 1'b0, ok1);
    offer32(1'b0, 1'b1, ok2);
    total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL chain_accept timeout"); end
    @(negedge clk);
    total++; if (digest[255:224] !== 32'h6a09e669)
      begin bad++; $display("FAIL chain_h0 got=%h exp=6a09e669", digest[255:224]); end
    total++; if (digest !== model_digest())
      begin bad++; $display("FAIL chain_digest got=%h exp=%h", digest, model_digest()); end
    total++; if (blk_cnt !== 16'd2) begin bad++; $display("FAIL chain_blk_cnt got=%0d exp=2", blk_cnt); end
    consume32();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [255:0] exp_d;
    for (int i = 0; i < 8; i++) blk_w[i] = $urandom;
    offer32(1'b1, 1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_accept timeout"); end
    exp_d = model_digest();
    // Offer another block while the digest is held; it must not be taken.
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_words = ~256'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (digest !== exp_d || digest_valid !== 1'b1)
        begin bad++; $display("FAIL bp_hold c=%0d got=%h v=%b exp=%h", c, digest, digest_valid, exp_d); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, in_ready); end
    end
    digest_ready = 1'b1;
    @(posedge clk);
    #1;
    digest_ready = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    model_close();
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || digest_valid !== 1'b0)
      begin bad++; $display("FAIL bp_release got ready=%b v=%b exp 1/0", in_ready, digest_valid); end
    total++; if (blk_cnt !== 16'd0) begin bad++; $display("FAIL bp_blk_cnt got=%0d exp=0", blk_cnt); end
  endtask

  task automatic test_reset_restart();
    bit ok1, ok2, ok3, ok4;
    for (int i = 0; i < 8; i++) blk_w[i] = $urandom;
    offer32(1'b1, 1'b0, ok1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_close();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (digest_valid !== 1'b0) begin bad++; $display("FAIL rr_no_digest c=%0d got=%b exp=0", c, digest_valid); end
    end
    // The rest of the aborted message now starts from a closed state.
    for (int i = 0; i < 8; i++) blk_w[i] = $urandom;
    offer32(1'b0, 1'b0, ok2);
    for (int i = 0; i < 8; i++) blk_w[i] = $urandom;
    offer32(1'b0, 1'b1, ok3);
    total++; if (!(ok1 && ok2 && ok3)) begin bad++; $display("FAIL rr_accept timeout"); end
    @(negedge clk);
    total++; if (digest !== model_digest())
      begin bad++; $display("FAIL rr_digest got=%h exp=%h", digest, model_digest()); end
    consume32();
    // in_first in the middle of an open message restarts the chain.
    for (int i = 0; i < 8; i++) blk_w[i] = $urandom;
    offer32(1'b1, 1'b0, ok1);
    for (int i = 0; i < 8; i++) blk_w[i] = $urandom;
    offer32(1'b0, 1'b0, ok2);
    for (int i = 0; i < 8; i++) blk_w[i] = $urandom;
    offer32(1'b1, 1'b0, ok3);
    for (int i = 0; i < 8; i++) blk_w[i] = $urandom;
    offer32(1'b0, 1'b1, ok4);
    total++; if (!(ok1 && ok2 && ok3 && ok4)) begin bad++; $display("FAIL restart_accept timeout"); end
    @(negedge clk);
    total++; if (digest !== model_digest())
      begin bad++; $display("FAIL restart_digest got=%h exp=%h", digest, model_digest()); end
    total++; if (blk_cnt !== 16'd2) begin bad++; $display("FAIL restart_blk_cnt got=%0d exp=2", blk_cnt); end
    consume32();
  endtask

  task automatic test_random();
    bit ok;
    int len, dly;
    logic [255:0] exp_d;
    for (int m = 0; m < 15; m++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        for (int i = 0; i < 8; i++) blk_w[i] = $urandom;
        offer32((b == 0) || ($urandom_range(0, 3) == 0), b == len - 1, ok);
        total++; if (!ok) begin bad++; $display("FAIL rand_accept m=%0d b=%0d timeout", m, b); end
      end
      exp_d = model_digest();
      dly = $urandom_range(0, 3);
      @(negedge clk);
      total++; if (digest_valid !== 1'b1 || digest !== exp_d)
        begin bad++; $display("FAIL rand_digest m=%0d got=%h v=%b exp=%h", m, digest, digest_valid, exp_d); end
      total++; if (blk_cnt !== mcnt[15:0])
        begin bad++; $display("FAIL rand_blk_cnt m=%0d got=%0d exp=%0d", m, blk_cnt, mcnt); end
      for (int d = 0; d < dly; d++) begin
        @(negedge clk);
        total++; if (digest !== exp_d) begin bad++; $display("FAIL rand_hold m=%0d got=%h exp=%h", m, digest, exp_d); end
      end
      consume32();
    end
  endtask

  task automatic test_wide_saturate();
    bit ok;
    logic [511:0] exp64;
    for (int i = 0; i < 8; i++) exp64[511-64*i -: 64] = iv512[i];
    for (int k = 0; k < 5; k++) begin
      offer64(k == 0, k == 4, ok);
      total++; if (!ok) begin bad++; $display("FAIL w64_accept k=%0d timeout", k); end
      @(negedge clk);
      total++; if (blk_cnt64 !== ((k + 1 > 3) ? 2'd3 : 2'(k + 1)))
        begin bad++; $display("FAIL w64_blk_cnt k=%0d got=%0d exp=%0d", k, blk_cnt64, (k + 1 > 3) ? 3 : k + 1); end
    end
    total++; if (digest64[511:448] !== 64'h6a09e667f3bcc908)
      begin bad++; $display("FAIL w64_h0 got=%h exp=6a09e667f3bcc908", digest64[511:448]); end
    total++; if (digest64 !== exp64 || digest_valid64 !== 1'b1)
      begin bad++; $display("FAIL w64_digest got=%h v=%b", digest64, digest_valid64); end
    digest_ready64 = 1'b1;
    @(posedge clk);
    #1;
    digest_ready64 = 1'b0;
    @(negedge clk);
    total++; if (blk_cnt64 !== 2'd0 || digest64 !== 512'h0)
      begin bad++; $display("FAIL w64_release cnt=%0d d=%h exp 0", blk_cnt64, digest64); end
  endtask

`ifdef SHA_DIGEST_TRUNC_EN
  task automatic test_trunc();
    bit ok;
    trunc_val = 1'b1;
    for (int i = 0; i < 8; i++) blk_w[i] = 32'h0;
    offer32(1'b1, 1'b1, ok);
    trunc_val = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL trunc_accept timeout"); end
    @(negedge clk);
    total++; if (digest[255:224] !== 32'hc1059ed8 || digest[31:0] !== 32'h0)
      begin bad++; $display("FAIL trunc_h0_h7 got=%h/%h exp=c1059ed8/0", digest[255:224], digest[31:0]); end
    total++; if (digest !== model_digest())
      begin bad++; $display("FAIL trunc_digest got=%h exp=%h", digest, model_digest()); end
    consume32();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_block();
    test_wrap();
    test_chaining();
    test_backpressure();
    test_reset_restart();
    test_random();
    test_wide_saturate();
`ifdef SHA_DIGEST_TRUNC_EN
    test_trunc();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
